// File: rtl/axi_sram_responder_if.sv
// AXI4 AW/W/B/AR/R channel bundle between a crossbar master port and a responder.
// Sideband fields (user, lock, cache, prot, qos, region) are not carried.
interface axi_channel #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 responder over a flop-array SRAM with independent read and write burst engines.
// Optional AXI_SRAM_RANGE_CHECK_EN: out-of-range beats are dropped/zeroed and answered with SLVERR.
module axi_sram_responder #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  axi_channel.slave   slave
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W     = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // Address of the following beat; reserved burst type behaves as INCR.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step, incr, wmask;
    step  = ADDR_WIDTH'(1) << size;
    incr  = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    wmask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wmask = wmask - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wmask) | (incr & wmask);
      default:     next_addr = incr;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q, arready_d;

  logic [ADDR_WIDTH-1:0] waddr_next_c, raddr_next_c;
  logic [IDX_W-1:0]      w_idx_c, r_load_idx_c;
  logic [DATA_WIDTH-1:0] r_mem_c;
  logic                  w_hs_c, mem_we_c, w_oor_c, r_oor_c;

  assign waddr_next_c = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
  assign raddr_next_c = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
  assign w_idx_c      = waddr_q[OFFS_W +: IDX_W];
  // Idle loads the AR address; during a burst the load is the next beat's word.
  assign r_load_idx_c = (r_state_q == R_IDLE) ? slave.araddr[OFFS_W +: IDX_W]
                                              : raddr_next_c[OFFS_W +: IDX_W];
  assign r_mem_c      = mem_q[r_load_idx_c];

`ifdef AXI_SRAM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
  logic [ADDR_WIDTH-1:0] r_load_addr_c;
  assign r_load_addr_c = (r_state_q == R_IDLE) ? slave.araddr : raddr_next_c;
  assign w_oor_c       = ({1'b0, waddr_q} >= MEM_BYTES);
  assign r_oor_c       = ({1'b0, r_load_addr_c} >= MEM_BYTES);
`else
  assign w_oor_c = 1'b0;
  assign r_oor_c = 1'b0;
`endif

  assign w_hs_c   = slave.wvalid && wready_q;
  assign mem_we_c = w_hs_c && !w_oor_c && !rst;

  // Byte-lane write; a read load in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (slave.wstrb[b]) mem_q[w_idx_c][b*8 +: 8] <= slave.wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    werr_d    = werr_q;
    case (w_state_q)
      W_IDLE: if (slave.awvalid && awready_q) begin
        waddr_d   = slave.awaddr;
        wlen_d    = slave.awlen;
        wsize_d   = slave.awsize;
        wburst_d  = slave.awburst;
        bid_d     = slave.awid;
        werr_d    = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs_c) begin
        waddr_d = waddr_next_c;
        werr_d  = werr_q | w_oor_c;
        if (slave.wlast) begin
          bresp_d   = (werr_q | w_oor_c) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (bvalid_q && slave.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: if (slave.arvalid && arready_q) begin
        raddr_d   = slave.araddr;
        rlen_d    = slave.arlen;
        rsize_d   = slave.arsize;
        rburst_d  = slave.arburst;
        rcnt_d    = slave.arlen;
        rid_d     = slave.arid;
        rdata_d   = r_oor_c ? '0 : r_mem_c;
        rresp_d   = r_oor_c ? RESP_SLVERR : RESP_OKAY;
        rlast_d   = (slave.arlen == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (rvalid_q && slave.rready) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          raddr_d = raddr_next_c;
          rdata_d = r_oor_c ? '0 : r_mem_c;
          rresp_d = r_oor_c ? RESP_SLVERR : RESP_OKAY;
          rcnt_d  = rcnt_q - 8'd1;
          rlast_d = (rcnt_q == 8'd1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  assign slave.awready = awready_q;
  assign slave.wready  = wready_q;
  assign slave.bvalid  = bvalid_q;
  assign slave.bid     = bid_q;
  assign slave.bresp   = bresp_q;
  assign slave.arready = arready_q;
  assign slave.rvalid  = rvalid_q;
  assign slave.rid     = rid_q;
  assign slave.rdata   = rdata_q;
  assign slave.rresp   = rresp_q;
  assign slave.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: burst-address table, directed corner sequences and
// randomized traffic checked against a byte-lane memory model.
module tb_axi_sram_responder;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned MEM_BYTES = DEPTH * DATA_W / 8;
`ifdef AXI_SRAM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) bus ();

  axi_sram_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .slave(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] rd_data [$];

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          size;
    int          burst;
    int          n;
    logic [31:0] exp [4];
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int w);
    return {32'hC0DE_0000 | 32'(w), ~32'(w) ^ 32'h5A5A_5A5A};
  endfunction

  // Byte address of beat i computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                            input int size, input int burst, input int i);
    longint unsigned step, wb, base, off, aa;
    aa   = 64'(a);
    step = 64'd1 << size;
    if (i == 0 || burst == 0) return a;
    if (burst == 2) begin
      wb   = 64'(len + 1) * step;
      base = (aa / wb) * wb;
      off  = ((aa - base) / step) * step;
      return 32'(base + (off + 64'(i) * step) % wb);
    end
    return 32'((aa / step) * step + 64'(i) * step);
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return RANGE_EN && (a >= MEM_BYTES);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [7:0] strb, input logic [63:0] d);
    int w;
    if (oor(a)) return;
    w = int'((a >> 3) % DEPTH);
    for (int b = 0; b < 8; b++) if (strb[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
  endtask

  function automatic logic [63:0] model_read(input logic [31:0] a);
    if (oor(a)) return 64'd0;
    return ref_mem[int'((a >> 3) % DEPTH)];
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input logic [63:0] data [$],
                           input logic [7:0] strb [$], input bit gaps, input int bstall);
    int guard;
    bit err = 1'b0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    bus.awsize = 3'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
    guard = 0;
    while (!bus.awready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check("aw_timeout", 1, 0);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps) while ($urandom_range(3) == 0) @(negedge clk);
      bus.wdata = data[i]; bus.wstrb = strb[i]; bus.wlast = (i == len); bus.wvalid = 1'b1;
      guard = 0;
      while (!bus.wready && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) check("w_timeout", 1, 0);
      err |= oor(beat_addr(addr, len, size, burst, i));
      model_write(beat_addr(addr, len, size, burst, i), strb[i], data[i]);
      @(negedge clk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
    end
    for (int k = 0; k < bstall; k++) begin
      check("b_stall_bvalid", 64'(bus.bvalid), 1);
      check("b_stall_awready", 64'(bus.awready), 0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    guard = 0;
    while (!bus.bvalid && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check("b_timeout", 1, 0);
    check("bresp", 64'(bus.bresp), err ? 64'd2 : 64'd0);
    check("bid", 64'(bus.bid), 64'(id));
    @(negedge clk);
    bus.bready = 1'b0;
    check("awready_after_b", 64'(bus.awready), 1);
  endtask

  // mode 0: rready high, 1: random, 2: repeating 1,0,0,1
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int mode);
    int guard, beats, cyc;
    bit rr, hold;
    logic [31:0] ba;
    rd_data.delete();
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    bus.arsize = 3'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
    guard = 0;
    while (!bus.arready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) check("ar_timeout", 1, 0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    beats = 0; cyc = 0;
    while (beats <= len && cyc < 3000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1)) : (cyc % 4 == 0 || cyc % 4 == 3);
      bus.rready = rr;
      hold = 1'b0;
      ba = beat_addr(addr, len, size, burst, beats);
      if (bus.rvalid && rr) begin
        rd_data.push_back(bus.rdata);
        check("r_data", bus.rdata, model_read(ba));
        check("r_resp", 64'(bus.rresp), oor(ba) ? 64'd2 : 64'd0);
        check("r_last", 64'(bus.rlast), 64'(beats == len));
        check("r_id", 64'(bus.rid), 64'(id));
        beats++;
      end else if (bus.rvalid) begin
        hold = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (hold) begin
        check("r_hold_valid", 64'(bus.rvalid), 1);
        check("r_hold_data", bus.rdata, model_read(ba));
        check("r_hold_last", 64'(bus.rlast), 64'(beats == len));
      end
    end
    bus.rready = 1'b0;
    if (beats <= len) check("r_timeout", 64'(beats), 64'(len + 1));
    check("rvalid_after_last", 64'(bus.rvalid), 0);
    check("arready_after_last", 64'(bus.arready), 1);
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input int len, input int size,
                         input int burst, input int n, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
    tbl[i].addr = a; tbl[i].len = len; tbl[i].size = size; tbl[i].burst = burst; tbl[i].n = n;
    tbl[i].exp[0] = e0; tbl[i].exp[1] = e1; tbl[i].exp[2] = e2; tbl[i].exp[3] = e3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] dq [$];
    logic [7:0]  sq [$];
    int burst, size, len;
    logic [31:0] addr, step;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    set_vec(0, 32'h100, 3, 3, 1, 4, 32'h100, 32'h108, 32'h110, 32'h118);
    set_vec(1, 32'h118, 3, 3, 2, 4, 32'h118, 32'h100, 32'h108, 32'h110);
    set_vec(2, 32'h040, 3, 3, 0, 4, 32'h040, 32'h040, 32'h040, 32'h040);
    set_vec(3, 32'h138, 1, 3, 2, 2, 32'h138, 32'h130, 32'h0,   32'h0);
    set_vec(4, 32'h103, 2, 3, 1, 3, 32'h103, 32'h108, 32'h110, 32'h0);
    set_vec(5, 32'h200, 3, 3, 3, 4, 32'h200, 32'h208, 32'h210, 32'h218);
    set_vec(6, 32'h10C, 3, 2, 2, 4, 32'h10C, 32'h100, 32'h104, 32'h108);

    repeat (3) @(negedge clk);
    check("rst_awready", 64'(bus.awready), 1);
    check("rst_arready", 64'(bus.arready), 1);
    check("rst_wready",  64'(bus.wready), 0);
    check("rst_bvalid",  64'(bus.bvalid), 0);
    check("rst_rvalid",  64'(bus.rvalid), 0);
    check("rst_rlast",   64'(bus.rlast), 0);
    check("rst_bresp",   64'(bus.bresp), 0);
    check("rst_rresp",   64'(bus.rresp), 0);
    check("rst_bid",     64'(bus.bid), 0);
    check("rst_rid",     64'(bus.rid), 0);
    check("rst_rdata",   bus.rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Preload every word with a known pattern using maximum-length bursts.
    for (int blk = 0; blk < 4; blk++) begin
      dq.delete(); sq.delete();
      for (int i = 0; i < 256; i++) begin dq.push_back(pat(blk * 256 + i)); sq.push_back(8'hFF); end
      axi_write(4'(blk), 32'(blk * 2048), 255, 3, 1, dq, sq, 1'b0, 0);
    end

    for (int v = 0; v < 7; v++) begin
      axi_read(4'(v + 1), tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, 0);
      check("tbl_nbeats", 64'(rd_data.size()), 64'(tbl[v].n));
      for (int j = 0; j < tbl[v].n && j < rd_data.size(); j++)
        check("tbl_beat", rd_data[j], pat(int'(tbl[v].exp[j] >> 3)));
    end

    dq = '{64'h11, 64'h22, 64'h33, 64'h44};
    sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    axi_write(4'd5, 32'h100, 3, 3, 1, dq, sq, 1'b0, 0);
    axi_read(4'd9, 32'h100, 3, 3, 1, 0);
    for (int j = 0; j < 4 && j < rd_data.size(); j++) check("incr_rd", rd_data[j], 64'(j + 1) * 64'h11);

    dq = '{64'hFFFF_FFFF_FFFF_FFFF}; sq = '{8'hFF};
    axi_write(4'd2, 32'h300, 0, 3, 1, dq, sq, 1'b0, 0);
    dq = '{64'h0}; sq = '{8'h0F};
    axi_write(4'd2, 32'h300, 0, 3, 1, dq, sq, 1'b0, 0);
    axi_read(4'd2, 32'h300, 0, 3, 1, 0);
    if (rd_data.size() > 0) check("partial_strobe", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    axi_read(4'd6, 32'h400, 7, 3, 1, 2);
    check("bp_nbeats", 64'(rd_data.size()), 8);
    dq = '{64'hA5A5_0000_1234_5678}; sq = '{8'hFF};
    axi_write(4'd7, 32'h480, 0, 3, 1, dq, sq, 1'b0, 5);

    // Reset in the middle of a 16-beat write.
    bus.awid = 4'd3; bus.awaddr = 32'h800; bus.awlen = 8'd15; bus.awsize = 3'd3;
    bus.awburst = 2'd1; bus.awvalid = 1'b1;
    for (int g = 0; g < 200 && !bus.awready; g++) @(negedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wdata = pat(i) ^ 64'hFF; bus.wstrb = 8'hFF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      for (int g = 0; g < 200 && !bus.wready; g++) @(negedge clk);
      model_write(32'h800 + 32'(8 * i), 8'hFF, pat(i) ^ 64'hFF);
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_awready", 64'(bus.awready), 1);
    check("midrst_wready",  64'(bus.wready), 0);
    check("midrst_bvalid",  64'(bus.bvalid), 0);
    dq = '{64'h0123_4567_89AB_CDEF}; sq = '{8'hFF};
    axi_write(4'd8, 32'h0, 0, 3, 1, dq, sq, 1'b0, 0);
    axi_read(4'd8, 32'h0, 0, 3, 1, 0);
    if (rd_data.size() > 0) check("post_rst_rd", rd_data[0], 64'h0123_4567_89AB_CDEF);
    axi_read(4'd4, 32'h808, 3, 3, 1, 0);

    // Byte address one past the memory: folds to word 0 unless range checking is built in.
    axi_read(4'd10, 32'h2000, 0, 3, 1, 0);
    if (rd_data.size() > 0) check("oor_rd", rd_data[0], RANGE_EN ? 64'd0 : 64'h0123_4567_89AB_CDEF);
    dq = '{64'hDEAD_BEEF_0BAD_F00D}; sq = '{8'hFF};
    axi_write(4'd11, 32'h2000, 0, 3, 1, dq, sq, 1'b0, 0);
    axi_read(4'd11, 32'h0, 0, 3, 1, 0);
    if (rd_data.size() > 0)
      check("oor_wr_word0", rd_data[0], RANGE_EN ? 64'h0123_4567_89AB_CDEF : 64'hDEAD_BEEF_0BAD_F00D);

    for (int n = 0; n < 60; n++) begin
      burst = $urandom_range(3);
      size  = $urandom_range(3);
      step  = 32'd1 << size;
      if (burst == 2) begin
        len  = (1 << $urandom_range(4, 1)) - 1;
        addr = 32'($urandom_range(32'h1D00)) & ~(step - 32'd1);
      end else begin
        len  = $urandom_range(15);
        addr = 32'($urandom_range(32'h1D00));
      end
      if ($urandom_range(1) == 1) begin
        dq.delete(); sq.delete();
        for (int i = 0; i <= len; i++) begin
          dq.push_back({$urandom, $urandom});
          sq.push_back(8'($urandom));
        end
        axi_write(4'($urandom), addr, len, size, burst, dq, sq, 1'b1, $urandom_range(2));
      end else begin
        axi_read(4'($urandom), addr, len, size, burst, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 responder (slave endpoint) backed by an internal flop-array SRAM.
- Terminates one crossbar master port; holds boot ROM shadow, scratchpad, or test memory.
- Independent read and write engines; supports FIXED/INCR/WRAP bursts up to 256 beats.
- Returns the widened crossbar ID unchanged on B/R.

Parameters:
- ID_WIDTH, 4: AXI ID width on this port (crossbar-widened ID).
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 64: AXI data width; power of 2, >= 32.
- MEM_DEPTH, 1024: number of DATA_WIDTH words; power of 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- slave  axi_channel.slave  ID_WIDTH/ADDR_WIDTH/DATA_WIDTH  AXI4 AW/W/B/AR/R channels; user, lock, cache, prot, qos, region ignored.

Behaviour:
- Reset state:
  - Write FSM W_IDLE, read FSM R_IDLE.
  - awready=1, arready=1; wready=0, bvalid=0, rvalid=0, rlast=0.
  - bresp=rresp=0, bid=rid=0, rdata=0.
  - Memory contents not reset.
- Word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] modulo MEM_DEPTH.
- Write FSM:
  - W_IDLE: awready=1. On aw handshake, latch id/addr/len/size/burst; go W_DATA. Next cycle awready=0, wready=1.
  - W_DATA: each w handshake writes bytes enabled by wstrb to the current word in the same cycle, then advances the address. On the wlast handshake go W_RESP. wlast is trusted; the beat count is not checked.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY. Hold until bready; then W_IDLE, awready=1 next cycle.
  - Minimum AW-to-B: 1 + (len+1) cycles.
- Read FSM:
  - R_IDLE: arready=1. On ar handshake, latch fields; load rdata from mem[word] (combinational array read, registered output). Next cycle rvalid=1, rid=latched id, rresp=OKAY, rlast=(len==0); state R_DATA.
  - R_DATA: on r handshake with rlast=0, advance the address and load the next word; rvalid stays 1. This gives one beat per cycle when rready is held high.
  - On the r handshake with rlast=1: rvalid=0; R_IDLE, arready=1.
  - rvalid, rdata, rlast are held stable while rready=0.
- Address advance, step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr+step, ADDR_WIDTH wrap.
  - WRAP: wraps within the aligned (len+1)<<size window.
  - Reserved burst 2'b11 is treated as INCR.
  - Unaligned start: first beat uses the given address; later beats are aligned.
- Simultaneous read load and write to the same word in one cycle: read returns old data (read-before-write).
- Both engines run concurrently; there is no ordering between them.
- Reset asserted mid-burst: both bursts are abandoned and all outputs return to reset values next cycle.

Optional Feature:
- Macro AXI_SRAM_RANGE_CHECK_EN.
- Defined: a beat whose byte address is >= MEM_DEPTH*DATA_WIDTH/8 is out of range.
  - Out-of-range write beats are suppressed, and a sticky flag makes bresp=SLVERR for that burst.
  - Out-of-range read beats return rdata=0 and rresp=SLVERR per beat.
  - The flag is cleared on AW accept.
- Undefined: address folds modulo MEM_DEPTH; responses are always OKAY.

Test Plan:
- INCR write, len=3, size=3, addr 0x100, data 0x11..0x44, wstrb all 1s; then read the same -> bresp=OKAY, bid=AW id; 4 R beats 0x11,0x22,0x33,0x44; rlast only on beat 4; rid matches.
- WRAP read, len=3, size=3, addr 0x118 over preloaded words -> beat addresses 0x118, 0x100, 0x108, 0x110.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with wstrb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- Backpressure: 8-beat read with rready toggling 1,0,0,1 and bready low for 5 cycles -> rdata/rvalid stable while stalled; no beat lost or duplicated; bvalid held for 5 cycles; awready=0 until B accepted.
- Reset asserted in the middle of a 16-beat write -> next cycle awready=1, wready=0, bvalid=0. A following 1-beat write/read to 0x0 completes normally.
- With AXI_SRAM_RANGE_CHECK_EN and MEM_DEPTH=1024: read at 0x2000 -> rresp=SLVERR, rdata=0; write at 0x2000 -> bresp=SLVERR, word 0 unchanged. Without the macro, both hit word 0 with OKAY.
